mem_access_sequencer: RTL and testbench
=======================================

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum number of REQ-state cycles without mem_ack before the access is aborted; legal range 1..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 issue  input  1  a decoded instruction is valid in the memory stage this cycle.
REQ-005 mem_rren  input  1  decoded load enable.
REQ-006 mem_wren  input  1  decoded store enable.
REQ-007 gp_we  input  1  decoded register-file write enable.
REQ-008 cad  input  5  decoded destination register address.
REQ-009 addr  input  32  effective address from the ALU.
REQ-010 wdata  input  32  store data.
REQ-011 mem_req  output  1  memory request, held until acknowledged or aborted.
REQ-012 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-013 mem_addr  output  32  latched address.
REQ-014 mem_wdata  output  32  latched store data.
REQ-015 mem_ack  input  1  memory completion; sampled only in state REQ.
REQ-016 mem_rdata  input  32  read data; valid in the cycle mem_ack=1.
REQ-017 stall  output  1  pipeline freeze request.
REQ-018 wb_we  output  1  register-file write strobe, one cycle.
REQ-019 wb_addr  output  5  register-file write address.
REQ-020 wb_data  output  32  register-file write data.
REQ-021 done  output  1  one-cycle pulse on successful access completion.
REQ-022 err  output  1  one-cycle pulse on timeout or illegal decode.

Function
REQ-023 The FSM SHALL have exactly three states: IDLE, REQ and WB.
REQ-024 In IDLE with issue=1 and exactly one of mem_rren/mem_wren set: latch addr, wdata, cad, gp_we and mem_wren into holding registers; next state REQ; clear timeout counter.
REQ-025 In IDLE, stall SHALL be driven combinationally high when issue=1 and (mem_rren XOR mem_wren)=1, and low otherwise.
REQ-026 In IDLE with issue=1 and mem_rren=mem_wren=1: no access; err pulses next cycle; state remains IDLE; stall stays low.
REQ-027 In IDLE with issue=0, or with no memory enable set: no action.
REQ-028 In REQ: mem_req=1, stall=1; mem_we, mem_addr and mem_wdata SHALL be driven from the holding registers and remain stable for the whole state.
REQ-029 In REQ with mem_ack=1 on a read: capture mem_rdata; next state WB.
REQ-030 In REQ with mem_ack=1 on a write: next state IDLE; done pulses next cycle.
REQ-031 In REQ without mem_ack: increment an 8-bit timeout counter; when the count reaches TIMEOUT, mem_req SHALL drop at the next edge, the state SHALL return to IDLE, err SHALL pulse for one cycle, and no writeback SHALL occur.
REQ-032 An ack arriving in the same cycle the count reaches TIMEOUT SHALL take priority: the access completes and err does not pulse.
REQ-033 In WB: stall=0; wb_addr=latched cad; wb_data=captured rdata; done=1; wb_we=1 only if latched gp_we=1 and latched cad != 0; next state IDLE unconditionally.
REQ-034 issue, mem_rren and mem_wren SHALL be ignored outside IDLE; the pipeline holds them stable while stall=1.
REQ-035 Read latency: issue in cycle T, ack in T+1 -> wb_we in T+2; stall high in T and T+1, low in T+2.
REQ-036 Write latency: issue in T, ack in T+1 -> done in T+2; stall low in T+2.
REQ-037 A new access issued in the cycle following WB or a write's completion SHALL be accepted (back-to-back operation, no bubble).

Reset
REQ-038 rst_n=0 SHALL immediately force state IDLE and drive mem_req, mem_we, stall, wb_we, done and err to 0; mem_addr, mem_wdata, wb_addr, wb_data and the timeout counter SHALL be 0.
REQ-039 Reset asserted mid-access SHALL abort the access: mem_req drops asynchronously and no wb_we, done or err is produced.

Verification
REQ-040 Load, cad=5, gp_we=1, addr=0x100, ack in first REQ cycle, rdata=0xDEADBEEF -> mem_req=1/mem_we=0 for 1 cycle, then wb_we=1, wb_addr=5, wb_data=0xDEADBEEF, done=1.
REQ-041 Store, addr=0x200, wdata=0x12345678, ack after 3 REQ cycles -> mem_addr/mem_wdata stable for 3 cycles, stall high for 4 cycles, done pulse, wb_we never asserted.
REQ-042 Load with no ack, TIMEOUT=15 -> mem_req high for exactly 15 cycles, then err pulse, return to IDLE, no wb_we; repeat with ack in the 15th cycle -> done, no err.
REQ-043 Load with cad=0 and gp_we=1 -> done pulses, wb_we stays 0.
REQ-044 issue with mem_rren=mem_wren=1 -> err pulse, mem_req and stall stay 0.
REQ-045 rst_n pulled low in the second REQ cycle -> mem_req and stall go 0 without waiting for clk; after release, state is IDLE and the next load completes normally.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Memory-stage access sequencer: issues a single load/store to the data bus,
// waits for the ack with a timeout, and performs the load writeback.
module mem_access_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue,
    input  logic        mem_rren,
    input  logic        mem_wren,
    input  logic        gp_we,
    input  logic [4:0]  cad,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t      state;
    state_t      state_nx;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic [31:0] rdata_q;
    logic [4:0]  h_cad;
    logic        h_gpwe;
    logic        h_we;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;
    logic        done_q;
    logic        err_q;
    logic        start_ok;
    logic        illegal;
    logic        timeout_hit;
    logic        accept;
    logic        capture;
    logic        set_done;
    logic        set_err;

    assign start_ok    = issue & (mem_rren ^ mem_wren);
    assign illegal     = issue & mem_rren & mem_wren;
    assign cnt_inc     = cnt + 8'd1;
    assign timeout_hit = (cnt_inc == TO_LIM);

    // Ack is checked before the timeout so a last-cycle ack still completes.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        set_done = 1'b0;
        set_err  = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        stall    = 1'b0;
        wb_we    = 1'b0;
        done     = done_q;
        unique case (state)
            IDLE: begin
                stall = start_ok;
                if (start_ok) begin
                    state_nx = REQ;
                    accept   = 1'b1;
                end else if (illegal) begin
                    set_err = 1'b1;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                mem_we  = h_we;
                stall   = 1'b1;
                if (mem_ack) begin
                    if (h_we) begin
                        state_nx = IDLE;
                        set_done = 1'b1;
                    end else begin
                        state_nx = WB;
                        capture  = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_nx = IDLE;
                    set_err  = 1'b1;
                end
            end
            WB: begin
                wb_we    = h_gpwe & (h_cad != 5'd0);
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            h_addr  <= '0;
            h_wdata <= '0;
            h_cad   <= '0;
            h_gpwe  <= 1'b0;
            h_we    <= 1'b0;
            rdata_q <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= set_done;
            err_q  <= set_err;
            if (accept) begin
                h_addr  <= addr;
                h_wdata <= wdata;
                h_cad   <= cad;
                h_gpwe  <= gp_we;
                h_we    <= mem_wren;
                cnt     <= '0;
            end else if (state == REQ && !mem_ack) begin
                cnt <= cnt_inc;
            end
            if (capture) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_addr  = h_addr;
    assign mem_wdata = h_wdata;
    assign wb_addr   = h_cad;
    assign wb_data   = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: vector table, randomized
// transactions against a transaction-level model, and hand-written corners.
module tb_mem_access_sequencer;

    localparam int TO = 15;
    localparam int NCYC = TO + 5;

    localparam int K_NOP = 0;
    localparam int K_RD = 1;
    localparam int K_WR = 2;
    localparam int K_ILL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue = 1'b0;
    logic        mem_rren = 1'b0;
    logic        mem_wren = 1'b0;
    logic        gp_we = 1'b0;
    logic [4:0]  cad = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        done;
    logic        err;

    int n_chk = 0;
    int n_fail = 0;

    mem_access_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .issue(issue),
        .mem_rren(mem_rren), .mem_wren(mem_wren), .gp_we(gp_we),
        .cad(cad), .addr(addr), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [4:0]  cad;
        logic        gpwe;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;
        int          e_req;
        int          e_stall;
        int          e_wbwe;
        int          e_done;
        int          e_err;
        int          e_evt;
    } vec_t;

    typedef struct {
        int          req;
        int          stl;
        int          wbwe;
        int          dn;
        int          er;
        int          evt;
        int          stable;
        logic [4:0]  wba;
        logic [31:0] wbd;
    } obs_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int kind, input logic [4:0] c,
                          input logic g, input logic [31:0] a,
                          input logic [31:0] w);
        issue    = (kind != K_NOP);
        mem_rren = (kind == K_RD) || (kind == K_ILL);
        mem_wren = (kind == K_WR) || (kind == K_ILL);
        gp_we    = g;
        cad      = c;
        addr     = a;
        wdata    = w;
    endtask

    task automatic clr_in();
        issue    = 1'b0;
        mem_rren = 1'b0;
        mem_wren = 1'b0;
    endtask

    // Drives one issue and observes the DUT for a fixed window.
    task automatic run_txn(input vec_t v, output obs_t o);
        int rq;
        o = '{default: 0};
        rq = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc == 0) set_in(v.kind, v.cad, v.gpwe, v.addr, v.wdata);
            else clr_in();
            mem_ack = 1'b0;
            #1;
            if (stall) o.stl++;
            if (wb_we) begin
                o.wbwe++;
                o.wba = wb_addr;
                o.wbd = wb_data;
            end
            if (done) o.dn++;
            if (err) o.er++;
            if ((done || err) && o.evt == 0) o.evt = cyc;
            if (mem_req) begin
                rq++;
                if (mem_addr !== v.addr || mem_wdata !== v.wdata ||
                    mem_we !== (v.kind == K_WR))
                    o.stable++;
                mem_ack   = (rq == v.ack_at);
                mem_rdata = mem_ack ? v.rdata : $urandom();
            end
        end
        o.req = rq;
    endtask

    // Transaction-level expectation from the access rules.
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        e.e_req = 0; e.e_stall = 0; e.e_wbwe = 0;
        e.e_done = 0; e.e_err = 0; e.e_evt = 0;
        if (v.kind == K_ILL) begin
            e.e_err = 1;
            e.e_evt = 1;
        end else if (v.kind != K_NOP) begin
            if (v.ack_at >= 1 && v.ack_at <= TO) begin
                e.e_req  = v.ack_at;
                e.e_done = 1;
                e.e_wbwe = (v.kind == K_RD && v.gpwe && v.cad != 0) ? 1 : 0;
            end else begin
                e.e_req = TO;
                e.e_err = 1;
            end
            e.e_stall = e.e_req + 1;
            e.e_evt   = e.e_req + 1;
        end
        return e;
    endfunction

    task automatic check_txn(input string tag, input vec_t e);
        obs_t o;
        run_txn(e, o);
        chk({tag, ".req_cycles"}, o.req, e.e_req);
        chk({tag, ".stall_cycles"}, o.stl, e.e_stall);
        chk({tag, ".wb_we"}, o.wbwe, e.e_wbwe);
        chk({tag, ".done"}, o.dn, e.e_done);
        chk({tag, ".err"}, o.er, e.e_err);
        chk({tag, ".evt_cycle"}, o.evt, e.e_evt);
        chk({tag, ".bus_stable"}, o.stable, 0);
        if (e.e_wbwe != 0) begin
            chk({tag, ".wb_addr"}, o.wba, e.cad);
            chk({tag, ".wb_data"}, o.wbd, e.rdata);
        end
    endtask

    vec_t tbl[$];
    vec_t rv;
    int   k;

    initial begin
        // kind cad gpwe addr wdata rdata ack | req stall wbwe done err evt
        tbl.push_back('{K_RD, 5'd5, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 1,
                        1, 2, 1, 1, 0, 2});
        tbl.push_back('{K_WR, 5'd7, 1'b0, 32'h200, 32'h12345678, 32'h0, 3,
                        3, 4, 0, 1, 0, 4});
        tbl.push_back('{K_RD, 5'd9, 1'b1, 32'h300, 32'h0, 32'h0, 0,
                        15, 16, 0, 0, 1, 16});
        tbl.push_back('{K_RD, 5'd9, 1'b1, 32'h304, 32'h0, 32'hCAFEF00D, 15,
                        15, 16, 1, 1, 0, 16});
        tbl.push_back('{K_RD, 5'd0, 1'b1, 32'h400, 32'h0, 32'h55AA55AA, 2,
                        2, 3, 0, 1, 0, 3});
        tbl.push_back('{K_ILL, 5'd3, 1'b1, 32'h500, 32'h1, 32'h0, 1,
                        0, 0, 0, 0, 1, 1});
        tbl.push_back('{K_NOP, 5'd3, 1'b1, 32'h600, 32'h1, 32'h0, 1,
                        0, 0, 0, 0, 0, 0});
        tbl.push_back('{K_RD, 5'd31, 1'b0, 32'h700, 32'h0, 32'h1, 1,
                        1, 2, 0, 1, 0, 2});
        tbl.push_back('{K_WR, 5'd1, 1'b1, 32'h800, 32'hFFFF0000, 32'h0, 0,
                        15, 16, 0, 0, 1, 16});
        tbl.push_back('{K_WR, 5'd1, 1'b1, 32'h804, 32'hA5A5A5A5, 32'h0, 14,
                        14, 15, 0, 1, 0, 15});

        // reset state
        #2;
        chk("rst.mem_req", mem_req, 0);
        chk("rst.stall", stall, 0);
        chk("rst.wb_we", wb_we, 0);
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.wb_data", wb_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            check_txn($sformatf("vec%0d", i), tbl[i]);
        end

        // back-to-back: load, store issued right after WB, then load
        @(negedge clk);
        set_in(K_RD, 5'd4, 1'b1, 32'hA0, 32'h0);
        #1 chk("b2b.c0_stall", stall, 1);
        @(negedge clk);
        clr_in();
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        #1 chk("b2b.c1_req", mem_req, 1);
        @(negedge clk);
        mem_ack = 1'b0;
        #1 chk("b2b.c2_wb_we", wb_we, 1);
        chk("b2b.c2_stall", stall, 0);
        chk("b2b.c2_wb_data", wb_data, 32'h11112222);
        @(negedge clk);
        set_in(K_WR, 5'd0, 1'b0, 32'hB0, 32'h33334444);
        #1 chk("b2b.c3_stall", stall, 1);
        @(negedge clk);
        clr_in();
        mem_ack = 1'b1;
        #1 chk("b2b.c4_req", mem_req, 1);
        chk("b2b.c4_we", mem_we, 1);
        chk("b2b.c4_addr", mem_addr, 32'hB0);
        @(negedge clk);
        set_in(K_RD, 5'd6, 1'b1, 32'hC0, 32'h0);
        mem_ack = 1'b0;
        #1 chk("b2b.c5_done", done, 1);
        chk("b2b.c5_stall", stall, 1);
        @(negedge clk);
        clr_in();
        mem_ack = 1'b1; mem_rdata = 32'h77778888;
        #1 chk("b2b.c6_req", mem_req, 1);
        chk("b2b.c6_addr", mem_addr, 32'hC0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1 chk("b2b.c7_wb_we", wb_we, 1);
        chk("b2b.c7_wb_addr", wb_addr, 6);
        @(negedge clk);

        // reset asserted in the second REQ cycle
        @(negedge clk);
        set_in(K_RD, 5'd8, 1'b1, 32'hD0, 32'h0);
        @(negedge clk);
        clr_in();
        @(negedge clk);
        #1 chk("rstmid.req_before", mem_req, 1);
        rst_n = 1'b0;
        #1 chk("rstmid.mem_req", mem_req, 0);
        chk("rstmid.stall", stall, 0);
        k = 0;
        repeat (3) begin
            @(negedge clk);
            #1 if (wb_we || done || err || mem_req) k++;
        end
        chk("rstmid.quiet", k, 0);
        rst_n = 1'b1;
        rv = '{K_RD, 5'd2, 1'b1, 32'hE0, 32'h0, 32'h9ABCDEF0, 1,
               0, 0, 0, 0, 0, 0};
        check_txn("rstmid.next", model(rv));

        // randomized transactions
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            rv.kind   = (k < 4) ? K_RD : (k < 8) ? K_WR : (k == 8) ? K_ILL : K_NOP;
            rv.cad    = 5'($urandom_range(0, 31));
            rv.gpwe   = 1'($urandom_range(0, 1));
            rv.addr   = $urandom();
            rv.wdata  = $urandom();
            rv.rdata  = $urandom();
            rv.ack_at = $urandom_range(0, 18);
            check_txn($sformatf("rnd%0d", i), model(rv));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
